// File: rtl/rock_pkg.sv
// Shared definitions for the baby-rocker sequencer.
//   rockState_t      : sequencer states (HALT only reachable with the watchdog)
//   *_DEF            : default setpoint bounds, steps and window timing
//   satAdd / satSub  : clamped arithmetic on SAT_W-bit values
// Optional feature: ROCK_SCHED_WATCHDOG_EN (see rock_scheduler.sv).
package rock_pkg;

  typedef enum logic [2:0] {IDLE, EVAL, DECIDE, APPLY, HALT} rockState_t;

  localparam int FREQ_W_DEF      = 8;
  localparam int AMP_W_DEF       = 8;
  localparam int FREQ_MIN_DEF    = 16;
  localparam int FREQ_MAX_DEF    = 200;
  localparam int AMP_MIN_DEF     = 8;
  localparam int AMP_MAX_DEF     = 240;
  localparam int FREQ_INIT_DEF   = 64;
  localparam int AMP_INIT_DEF    = 64;
  localparam int FSTEP_DEF       = 4;
  localparam int ASTEP_DEF       = 8;
  localparam int HP_BASE_DEF     = 256;
  localparam int EVAL_CYCLES_DEF = 1024;
  localparam int STRESS_THR_DEF  = 256;

  // Consecutive stressed windows that trip the watchdog.
  localparam int WD_WINDOWS = 4;

  // Setpoints are widened to SAT_W bits before stepping, so any register
  // narrower than SAT_W can never wrap while being clamped.
  localparam int SAT_W = 17;

  function automatic logic [SAT_W-1:0] satAdd(input logic [SAT_W-1:0] value,
                                              input logic [SAT_W-1:0] step,
                                              input logic [SAT_W-1:0] hi);
    logic [SAT_W-1:0] sum;
    sum = value + step;
    return (sum > hi) ? hi : sum;
  endfunction

  // Compare before subtracting so the result never underflows.
  function automatic logic [SAT_W-1:0] satSub(input logic [SAT_W-1:0] value,
                                              input logic [SAT_W-1:0] step,
                                              input logic [SAT_W-1:0] lo);
    return (value < (lo + step)) ? lo : (value - step);
  endfunction

endpackage

// File: rtl/rock_scheduler_swing_timer.sv
// swing_timer: reloadable half-period down-counter driving the swing direction.
//   clk, reset     : clock, synchronous active-high reset
//   run_i          : count this cycle
//   restart_i      : reload the counter (used while the sequencer is idle)
//   halfPeriod_i   : half-period length in cycles, captured at each reload
//   expire_o       : one-cycle strobe on the last cycle of a half-period
//   motorDir_o     : swing direction, toggles on every expiry
// With run_i and restart_i both low the counter and direction are frozen.
module swing_timer #(
  parameter int HP_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_i,
  input  logic            restart_i,
  input  logic [HP_W-1:0] halfPeriod_i,
  output logic            expire_o,
  output logic            motorDir_o
);

  logic [HP_W-1:0] cnt_q;
  logic            dir_q;

  assign expire_o   = run_i && (cnt_q == '0);
  assign motorDir_o = dir_q;

  // The count is loaded with halfPeriod-1 so that a half-period lasts
  // exactly halfPeriod running cycles; a changed half-period is only picked
  // up here, at the reload, never in the middle of a swing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (restart_i) begin
      cnt_q <= halfPeriod_i - HP_W'(1);
    end else if (run_i) begin
      if (expire_o) begin
        cnt_q <= halfPeriod_i - HP_W'(1);
        dir_q <= ~dir_q;
      end else begin
        cnt_q <= cnt_q - HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/rock_scheduler.sv
// rock_scheduler: sequencer for the baby-rocker control loop.
// Measures stress over fixed windows, steps the path-finder once per window
// and applies its commands to clamped frequency/amplitude setpoints while a
// swing timer rocks the motor.
//   clk, reset                   : clock, synchronous active-high reset
//   enable                       : run request (level)
//   stress                       : synchronised stress sensor
//   cmd_amin/cmd_fplus/cmd_fmin  : path-finder commands, sampled in APPLY
//   pf_step                      : one-cycle strobe to the path-finder
//   pf_flow                      : 1 = stress not decreasing vs last window
//   pf_stress                    : last window was stressed
//   freq, amp                    : setpoints to the motor driver
//   motor_dir                    : swing direction
//   busy                         : sequencer not idle
// Define ROCK_SCHED_WATCHDOG_EN to halt after WD_WINDOWS stressed windows in a row.
module rock_scheduler
  import rock_pkg::*;
#(
  parameter int FREQ_W      = FREQ_W_DEF,
  parameter int AMP_W       = AMP_W_DEF,
  parameter int FREQ_MIN    = FREQ_MIN_DEF,
  parameter int FREQ_MAX    = FREQ_MAX_DEF,
  parameter int AMP_MIN     = AMP_MIN_DEF,
  parameter int AMP_MAX     = AMP_MAX_DEF,
  parameter int FREQ_INIT   = FREQ_INIT_DEF,
  parameter int AMP_INIT    = AMP_INIT_DEF,
  parameter int FSTEP       = FSTEP_DEF,
  parameter int ASTEP       = ASTEP_DEF,
  parameter int HP_BASE     = HP_BASE_DEF,
  parameter int EVAL_CYCLES = EVAL_CYCLES_DEF,
  parameter int STRESS_THR  = STRESS_THR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stress,
  input  logic              cmd_amin,
  input  logic              cmd_fplus,
  input  logic              cmd_fmin,
  output logic              pf_step,
  output logic              pf_flow,
  output logic              pf_stress,
  output logic [FREQ_W-1:0] freq,
  output logic [AMP_W-1:0]  amp,
  output logic              motor_dir,
  output logic              busy
);

  localparam int WIN_W = $clog2(EVAL_CYCLES);
  // One bit wider than the window counter so a fully stressed window fits.
  localparam int CNT_W = WIN_W + 1;
  localparam int HP_W  = $clog2(HP_BASE + 1);

  rockState_t        state_q;
  logic [WIN_W-1:0]  winCnt_q;
  logic [CNT_W-1:0]  stressCnt_q, stressCnt_d, prevCnt_q;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [AMP_W-1:0]  amp_q, amp_d;
  logic              pfStep_q, pfFlow_q, pfStress_q;
  logic              lastWin, windowStressed;
  logic              swingRun, swingRestart;
  logic [HP_W-1:0]   halfPeriod;
  logic              unusedSwingExpire;

`ifdef ROCK_SCHED_WATCHDOG_EN
  logic [2:0]        stressRun_q;
`endif

  assign pf_step   = pfStep_q;
  assign pf_flow   = pfFlow_q;
  assign pf_stress = pfStress_q;
  assign freq      = freq_q;
  assign amp       = amp_q;
  assign busy      = (state_q != IDLE);

  assign lastWin        = (winCnt_q == WIN_W'(EVAL_CYCLES - 1));
  assign windowStressed = (stressCnt_d > CNT_W'(STRESS_THR));

  // The swing keeps going across the decision cycles; idle restarts it so a
  // fresh run always begins with a full half-period, HALT freezes it.
  assign swingRun     = (state_q == EVAL) || (state_q == DECIDE) || (state_q == APPLY);
  assign swingRestart = (state_q == IDLE);
  assign halfPeriod   = HP_W'(HP_BASE) - HP_W'(freq_q);

  swing_timer #(
    .HP_W(HP_W)
  ) u_swing (
    .clk         (clk),
    .reset       (reset),
    .run_i       (swingRun),
    .restart_i   (swingRestart),
    .halfPeriod_i(halfPeriod),
    .expire_o    (unusedSwingExpire),
    .motorDir_o  (motor_dir)
  );

  // Next-value arithmetic: the stress count sticks at all-ones, the setpoints
  // are stepped in SAT_W bits and clamped. Opposing freq commands cancel; a
  // down request on amp wins over the automatic up-step of a calm window.
  always_comb begin
    stressCnt_d = stressCnt_q;
    if (stress && (stressCnt_q != '1)) begin
      stressCnt_d = stressCnt_q + CNT_W'(1);
    end

    freq_d = freq_q;
    if (cmd_fplus && !cmd_fmin) begin
      freq_d = FREQ_W'(satAdd(SAT_W'(freq_q), SAT_W'(FSTEP), SAT_W'(FREQ_MAX)));
    end else if (cmd_fmin && !cmd_fplus) begin
      freq_d = FREQ_W'(satSub(SAT_W'(freq_q), SAT_W'(FSTEP), SAT_W'(FREQ_MIN)));
    end

    amp_d = amp_q;
    if (cmd_amin) begin
      amp_d = AMP_W'(satSub(SAT_W'(amp_q), SAT_W'(ASTEP), SAT_W'(AMP_MIN)));
    end else if (!pfStress_q) begin
      amp_d = AMP_W'(satAdd(SAT_W'(amp_q), SAT_W'(ASTEP), SAT_W'(AMP_MAX)));
    end
  end

  // Sequencer. The window verdict is registered on the last EVAL edge using
  // the count including that final cycle, so pf_step/pf_flow/pf_stress all
  // appear together in DECIDE. Dropping enable anywhere goes straight to
  // IDLE without touching the setpoints or prevCnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      winCnt_q    <= '0;
      stressCnt_q <= '0;
      prevCnt_q   <= '0;
      freq_q      <= FREQ_W'(FREQ_INIT);
      amp_q       <= AMP_W'(AMP_INIT);
      pfStep_q    <= 1'b0;
      pfFlow_q    <= 1'b0;
      pfStress_q  <= 1'b0;
`ifdef ROCK_SCHED_WATCHDOG_EN
      stressRun_q <= '0;
`endif
    end else begin
      pfStep_q <= 1'b0;
      case (state_q)
        IDLE: begin
          winCnt_q    <= '0;
          stressCnt_q <= '0;
          if (enable) state_q <= EVAL;
        end
        EVAL: begin
          if (!enable) begin
            state_q     <= IDLE;
            winCnt_q    <= '0;
            stressCnt_q <= '0;
          end else begin
            stressCnt_q <= stressCnt_d;
            if (lastWin) begin
              state_q    <= DECIDE;
              winCnt_q   <= '0;
              pfStress_q <= windowStressed;
              pfFlow_q   <= (stressCnt_d >= prevCnt_q);
              prevCnt_q  <= stressCnt_d;
              pfStep_q   <= 1'b1;
`ifdef ROCK_SCHED_WATCHDOG_EN
              if (!windowStressed) begin
                stressRun_q <= '0;
              end else if (stressRun_q != 3'(WD_WINDOWS)) begin
                stressRun_q <= stressRun_q + 3'd1;
              end
`endif
            end else begin
              winCnt_q <= winCnt_q + WIN_W'(1);
            end
          end
        end
        DECIDE: begin
          state_q <= enable ? APPLY : IDLE;
        end
        APPLY: begin
          winCnt_q    <= '0;
          stressCnt_q <= '0;
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            state_q <= EVAL;
`ifdef ROCK_SCHED_WATCHDOG_EN
            if (stressRun_q == 3'(WD_WINDOWS)) begin
              amp_q   <= AMP_W'(AMP_MIN);
              state_q <= HALT;
            end
`endif
          end
        end
`ifdef ROCK_SCHED_WATCHDOG_EN
        HALT: begin
          if (!enable) begin
            state_q     <= IDLE;
            stressRun_q <= '0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rock_scheduler.sv
// Bench for rock_scheduler: a window-level model of the sequencer checked
// against the default-parameter DUT every cycle, plus a short-window
// instance with setpoints next to the bounds for the clamping cases.
module tb_rock_scheduler;

  localparam int EC   = 1024;
  localparam int THR  = 256;
  localparam int HPB  = 256;
  localparam int EC2  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT, default parameters
  logic       enable = 1'b0, stress = 1'b0;
  logic       cmdAmin = 1'b0, cmdFplus = 1'b0, cmdFmin = 1'b0;
  logic       pfStep, pfFlow, pfStress, motorDir, busy;
  logic [7:0] freq, amp;

  rock_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .stress(stress),
    .cmd_amin(cmdAmin), .cmd_fplus(cmdFplus), .cmd_fmin(cmdFmin),
    .pf_step(pfStep), .pf_flow(pfFlow), .pf_stress(pfStress),
    .freq(freq), .amp(amp), .motor_dir(motorDir), .busy(busy)
  );

  // Short-window DUT started close to the saturation bounds
  logic       enable2 = 1'b0, stress2 = 1'b0;
  logic       cmdAmin2 = 1'b0, cmdFplus2 = 1'b0, cmdFmin2 = 1'b0;
  logic       pfStep2, pfFlow2, pfStress2, motorDir2, busy2;
  logic [7:0] freq2, amp2;

  rock_scheduler #(
    .EVAL_CYCLES(EC2), .FREQ_INIT(198), .AMP_INIT(11)
  ) dutSat (
    .clk(clk), .reset(reset), .enable(enable2), .stress(stress2),
    .cmd_amin(cmdAmin2), .cmd_fplus(cmdFplus2), .cmd_fmin(cmdFmin2),
    .pf_step(pfStep2), .pf_flow(pfFlow2), .pf_stress(pfStress2),
    .freq(freq2), .amp(amp2), .motor_dir(motorDir2), .busy(busy2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Window-level model: position inside the decision period (0..EC-1 is the
  // measurement window, EC the step cycle, EC+1 the apply cycle), the stress
  // tally, the setpoints and the swing's remaining half-period.
  bit mLive = 0, mRun = 0, mDir = 0, mFlow = 0, mStress = 0;
  int mPos = 0, mCnt = 0, mPrev = 0, mFreq = 64, mAmp = 64, mHpLeft = HPB - 64;

  always @(posedge clk) begin
    if (reset) begin
      mLive = 1; mRun = 0; mDir = 0; mFlow = 0; mStress = 0;
      mPos = 0; mCnt = 0; mPrev = 0; mFreq = 64; mAmp = 64; mHpLeft = HPB - 64;
    end else begin
      if (mRun) begin
        mHpLeft--;
        if (mHpLeft == 0) begin
          mDir = !mDir;
          mHpLeft = HPB - mFreq;
        end
      end else begin
        mHpLeft = HPB - mFreq;
      end
      if (!mRun) begin
        if (enable) begin mRun = 1; mPos = 0; mCnt = 0; end
      end else if (!enable) begin
        mRun = 0;
      end else if (mPos == EC + 1) begin
        if (cmdFplus && !cmdFmin) mFreq = (mFreq + 4 > 200) ? 200 : mFreq + 4;
        if (cmdFmin && !cmdFplus) mFreq = (mFreq - 4 < 16) ? 16 : mFreq - 4;
        if (cmdAmin) mAmp = (mAmp - 8 < 8) ? 8 : mAmp - 8;
        else if (!mStress) mAmp = (mAmp + 8 > 240) ? 240 : mAmp + 8;
        mPos = 0;
        mCnt = 0;
      end else begin
        if (mPos < EC) begin
          if (stress && mCnt < 2047) mCnt++;
          if (mPos == EC - 1) begin
            mStress = (mCnt > THR);
            mFlow = (mCnt >= mPrev);
            mPrev = mCnt;
          end
        end
        mPos++;
      end
    end
  end

  // Every-cycle comparison of the main DUT against the model
  always @(negedge clk) begin
    if (mLive) begin
      checkOutput("busy", busy, mRun);
      checkOutput("pf_step", pfStep, (mRun && mPos == EC) ? 1 : 0);
      checkOutput("pf_flow", pfFlow, mFlow);
      checkOutput("pf_stress", pfStress, mStress);
      checkOutput("freq", freq, mFreq);
      checkOutput("amp", amp, mAmp);
      checkOutput("motor_dir", motorDir, mDir);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full decision period starting at the first EVAL cycle: stress high
  // for the first stressCycles cycles, commands held for the whole period.
  task automatic applyStimulus(input int stressCycles, input bit fp, input bit fm, input bit am);
    cmdFplus = fp; cmdFmin = fm; cmdAmin = am;
    for (int c = 0; c < EC + 2; c++) begin
      stress = (c < stressCycles);
      tick();
    end
    stress = 0; cmdFplus = 0; cmdFmin = 0; cmdAmin = 0;
  endtask

  task automatic waitStep(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pfStep && n < 1500);
  endtask

  task automatic waitStep2(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pfStep2 && n < 40);
  endtask

  task automatic mainSequence();
    int n, consumed, t0;
    logic prevDir;
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_freq", freq, 64);
    checkOutput("reset_amp", amp, 64);
    checkOutput("reset_dir", motorDir, 0);
    checkOutput("reset_pf_step", pfStep, 0);

    // First window: calm, no commands. pf_step lands on cycle 1026 counting
    // the cycle enable is raised as cycle 1, i.e. 1025 edges later.
    enable = 1;
    waitStep(n);
    checkOutput("enable_to_step", n, 1025);
    checkOutput("w1_pf_stress", pfStress, 0);
    checkOutput("w1_pf_flow", pfFlow, 1);
    tick();
    tick();
    checkOutput("w1_amp", amp, 72);
    checkOutput("w1_freq", freq, 64);

    // 300 stressed cycles, fplus: stressed, amp held, freq up
    applyStimulus(300, 1, 0, 0);
    checkOutput("w2_pf_stress", pfStress, 1);
    checkOutput("w2_pf_flow", pfFlow, 1);
    checkOutput("w2_freq", freq, 68);
    checkOutput("w2_amp", amp, 72);

    // 100 stressed cycles: calm but decreasing
    applyStimulus(100, 0, 0, 0);
    checkOutput("w3_pf_flow", pfFlow, 0);
    checkOutput("w3_amp", amp, 80);

    // Both freq commands cancel, amin steps amp down
    applyStimulus(0, 1, 1, 1);
    checkOutput("w4_freq", freq, 68);
    checkOutput("w4_amp", amp, 72);

    // Half-period at freq 68 is 256-68 = 188 cycles
    consumed = 0;
    prevDir = motorDir;
    while (motorDir == prevDir && consumed < 400) begin tick(); consumed++; end
    t0 = consumed;
    prevDir = motorDir;
    while (motorDir == prevDir && consumed < 800) begin tick(); consumed++; end
    checkOutput("half_period", consumed - t0, 188);
    for (int c = consumed; c < EC + 2; c++) tick();
    checkOutput("w5_amp", amp, 80);

    // Drop enable mid-window: idle next cycle, setpoints kept, no step
    repeat (500) tick();
    enable = 0;
    tick();
    checkOutput("drop_busy", busy, 0);
    repeat (20) tick();
    checkOutput("drop_freq", freq, 68);
    checkOutput("drop_amp", amp, 80);
    enable = 1;
    waitStep(n);
    checkOutput("reenable_to_step", n, 1025);
    tick();
    tick();
    checkOutput("w6_amp", amp, 88);
  endtask

  task automatic satSequence();
    int n;
    wait (!reset);
    tick();
    enable2 = 1; cmdFplus2 = 1; cmdAmin2 = 1;
    waitStep2(n);
    checkOutput("sat_step_latency", n, EC2 + 1);
    tick();
    tick();
    checkOutput("sat_freq_198", freq2, 200);
    checkOutput("sat_amp_11", amp2, 8);
    waitStep2(n);
    tick();
    tick();
    checkOutput("sat_freq_hold", freq2, 200);
    checkOutput("sat_amp_hold", amp2, 8);
    cmdFplus2 = 0; cmdFmin2 = 1; cmdAmin2 = 0;
    waitStep2(n);
    tick();
    tick();
    checkOutput("sat_freq_down", freq2, 196);
    checkOutput("sat_amp_up", amp2, 16);
    enable2 = 0; cmdFmin2 = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    $display("[TB] reset released");
    fork
      mainSequence();
      satSequence();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no end of test, expected finish before %0t", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
